// File: rtl/hand_row_render.sv
// hand_row_render
// Draws one horizontal row of playing cards on a VGA raster. Each of SLOTS
// slots holds a 6-bit card code (0..53 = card, 54..63 = empty). A running
// slot/offset tracker follows h_cnt without any divider. A 3-stage pipeline
// drives the card pixel memory and merges its data with background and
// highlight colours.
//
// Ports:
//   clk_25MHz   pixel clock
//   rst         asynchronous active-high reset
//   h_cnt/v_cnt VGA column/row; h_cnt advances by 1 per clock within a line
//   valid       display-active flag
//   slot_we/slot_idx/slot_card   slot table write port
//   sel_en/sel_idx               highlighted slot
//   pixel_x/pixel_y/card_type    address to the card pixel memory (stage 1)
//   card_pixel  memory data, valid one clock after the address
//   rgb/rgb_valid               final colour, 3 clocks after h_cnt/v_cnt
//
// Handshake: there is no backpressure. Every clock accepts one raster
// position, and rgb_valid/rgb for it appear exactly three clocks later.
module hand_row_render #(
  parameter int          X0    = 64,
  parameter int          Y0    = 400,
  parameter int          SLOTS = 16,
  parameter int          PITCH = 36,
  parameter logic [11:0] BG    = 12'h063,
  parameter logic [11:0] HL    = 12'hFF0
) (
  input  logic        clk_25MHz,
  input  logic        rst,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic        slot_we,
  input  logic [3:0]  slot_idx,
  input  logic [5:0]  slot_card,
  input  logic        sel_en,
  input  logic [3:0]  sel_idx,
  output logic [5:0]  pixel_x,
  output logic [5:0]  pixel_y,
  output logic [5:0]  card_type,
  input  logic [11:0] card_pixel,
  output logic [11:0] rgb,
  output logic        rgb_valid
);

  localparam logic [9:0] X0_L       = 10'(X0);
  localparam logic [9:0] Y0_L       = 10'(Y0);
  localparam logic [9:0] Y_END      = 10'(Y0 + 46);
  localparam logic [4:0] SLOTS_L    = 5'(SLOTS);
  localparam logic [5:0] PITCH_LAST = 6'(PITCH - 1);

  // Slot table. Entries at or above SLOTS are never written and keep the
  // empty code, so the 4-bit tracker can index the array directly.
  logic [5:0] slot_tab [16];

  logic [3:0] slot_q;
  logic [5:0] off_q;
  logic [3:0] frame_cnt;
  logic       blink;

  // Stage 0 (combinational view of the current raster position)
  logic       at_x0;
  logic [3:0] cur_slot;
  logic [5:0] cur_off;
  logic [5:0] cur_code;
  logic [5:0] row0;
  logic       hit0, border0, sel0;

  // Stage 1 / stage 2 flags
  logic s1_hit, s1_valid, s1_border, s1_sel;
  logic s2_hit, s2_valid, s2_border, s2_sel;

  // The tracker reload is applied combinationally so that the cycle with
  // h_cnt==X0 already sees slot 0 / offset 0; the registers then hold the
  // position for the following column.
  always_comb begin
    at_x0    = (h_cnt == X0_L);
    cur_slot = at_x0 ? 4'd0 : slot_q;
    cur_off  = at_x0 ? 6'd0 : off_q;
    cur_code = slot_tab[cur_slot];
    row0     = 6'(v_cnt - Y0_L);
    hit0     = valid && (h_cnt >= X0_L) && (cur_off < 6'd32) &&
               ({1'b0, cur_slot} < SLOTS_L) &&
               (v_cnt >= Y0_L) && (v_cnt < Y_END) && (cur_code <= 6'd53);
    border0  = (cur_off[4:0] == 5'd0) || (cur_off[4:0] == 5'd31) ||
               (row0 == 6'd0) || (row0 == 6'd45);
    sel0     = sel_en && ({1'b0, sel_idx} < SLOTS_L) && (cur_slot == sel_idx);
  end

  // Slot table writes; a write lands at the edge, so the scan in the same
  // cycle still reads the previous code.
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) slot_tab[i] <= 6'd63;
    end else if (slot_we && ({1'b0, slot_idx} < SLOTS_L)) begin
      slot_tab[slot_idx] <= slot_card;
    end
  end

  // Slot/offset tracker; slot saturates at 15 past the end of the row.
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      slot_q <= 4'd0;
      off_q  <= 6'd0;
    end else if (cur_off == PITCH_LAST) begin
      off_q  <= 6'd0;
      slot_q <= (cur_slot == 4'd15) ? cur_slot : cur_slot + 4'd1;
    end else begin
      off_q  <= cur_off + 6'd1;
      slot_q <= cur_slot;
    end
  end

  // Frame counter and blink (blink toggles every 16 frames).
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      frame_cnt <= 4'd0;
      blink     <= 1'b0;
    end else if ((h_cnt == 10'd0) && (v_cnt == 10'd0)) begin
      frame_cnt <= frame_cnt + 4'd1;
      if (frame_cnt == 4'hF) blink <= ~blink;
    end
  end

  // Stage 1: memory address plus flags. Address is forced to 0 on a miss.
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      pixel_x   <= 6'd0;
      pixel_y   <= 6'd0;
      card_type <= 6'd0;
      s1_hit    <= 1'b0;
      s1_valid  <= 1'b0;
      s1_border <= 1'b0;
      s1_sel    <= 1'b0;
    end else begin
      pixel_x   <= hit0 ? {1'b0, cur_off[4:0]} : 6'd0;
      pixel_y   <= hit0 ? row0 : 6'd0;
      card_type <= hit0 ? cur_code : 6'd0;
      s1_hit    <= hit0;
      s1_valid  <= valid;
      s1_border <= border0;
      s1_sel    <= sel0;
    end
  end

  // Stage 2: flags wait for the memory read; card_pixel is valid here.
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      s2_hit    <= 1'b0;
      s2_valid  <= 1'b0;
      s2_border <= 1'b0;
      s2_sel    <= 1'b0;
    end else begin
      s2_hit    <= s1_hit;
      s2_valid  <= s1_valid;
      s2_border <= s1_border;
      s2_sel    <= s1_sel;
    end
  end

  // Output colour selection.
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      rgb       <= 12'h000;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= s2_valid;
      if (!s2_valid)                                 rgb <= 12'h000;
      else if (s2_hit && s2_sel && s2_border && blink) rgb <= HL;
      else if (s2_hit)                               rgb <= card_pixel;
      else                                           rgb <= BG;
    end
  end

endmodule
